// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter that shares one AXI write port (AW, W, B) among NUM_MASTERS requesters.
// Only one transaction is in flight: the owner is registered in IDLE and kept until its B handshake.
module axi_write_arbiter #(
   parameter int NUM_MASTERS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [32*NUM_MASTERS-1:0] m_awaddr,
   input  logic [8*NUM_MASTERS-1:0]  m_awlen,
   input  logic [3*NUM_MASTERS-1:0]  m_awsize,
   input  logic [NUM_MASTERS-1:0]    m_awvalid,
   output logic [NUM_MASTERS-1:0]    m_awready,
   input  logic [32*NUM_MASTERS-1:0] m_wdata,
   input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
   input  logic [NUM_MASTERS-1:0]    m_wlast,
   input  logic [NUM_MASTERS-1:0]    m_wvalid,
   output logic [NUM_MASTERS-1:0]    m_wready,
   output logic [NUM_MASTERS-1:0]    m_bvalid,
   input  logic [NUM_MASTERS-1:0]    m_bready,
   output logic [31:0]               s_awaddr,
   output logic [7:0]                s_awlen,
   output logic [2:0]                s_awsize,
   output logic                      s_awvalid,
   input  logic                      s_awready,
   output logic [31:0]               s_wdata,
   output logic [3:0]                s_wstrb,
   output logic                      s_wlast,
   output logic                      s_wvalid,
   input  logic                      s_wready,
   input  logic                      s_bvalid,
   output logic                      s_bready,
   output logic [NUM_MASTERS-1:0]    grant,
   output logic                      busy
);

   localparam int N  = NUM_MASTERS;
   localparam int IW = (N > 2) ? 2 : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]    r_state;
   logic [N-1:0]  r_grant;
   logic [IW-1:0] r_gidx;
   logic [IW-1:0] r_last;

   logic [IW-1:0] w_pick;
   logic [IW-1:0] w_cand;
   logic          w_found;
   logic [N-1:0]  w_pick_oh;

   logic [31:0]   w_awaddr_g;
   logic [7:0]    w_awlen_g;
   logic [2:0]    w_awsize_g;
   logic [31:0]   w_wdata_g;
   logic [3:0]    w_wstrb_g;

   // Search starts just after the last served master, so the previous owner has lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = IW'((int'(r_last) + k) % N);
         if (!w_found && m_awvalid[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pick_oh
         assign w_pick_oh[gi] = (w_pick == IW'(gi));
      end
   endgenerate

   assign w_awaddr_g = m_awaddr[32*r_gidx +: 32];
   assign w_awlen_g  = m_awlen[8*r_gidx +: 8];
   assign w_awsize_g = m_awsize[3*r_gidx +: 3];
   assign w_wdata_g  = m_wdata[32*r_gidx +: 32];
   assign w_wstrb_g  = m_wstrb[4*r_gidx +: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(N - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|m_awvalid) begin
                  r_gidx  <= w_pick;
                  r_grant <= w_pick_oh;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (s_awvalid && s_awready) r_state <= ST_DATA;
            end
            ST_DATA: begin
               // The burst ends on wlast alone; beats are never counted against awlen.
               if (s_wvalid && s_wready && s_wlast) r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (s_bvalid && s_bready) begin
                  r_last  <= r_gidx;
                  r_grant <= '0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Each channel is routed only during its own phase; everything else is held at zero.
   always_comb begin
      s_awaddr  = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_awvalid = 1'b0;
      m_awready = '0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      s_wvalid  = 1'b0;
      m_wready  = '0;
      m_bvalid  = '0;
      s_bready  = 1'b0;
      case (r_state)
         ST_ADDR: begin
            s_awaddr  = w_awaddr_g;
            s_awlen   = w_awlen_g;
            s_awsize  = w_awsize_g;
            s_awvalid = m_awvalid[r_gidx];
            m_awready = r_grant & {N{s_awready}};
         end
         ST_DATA: begin
            s_wdata  = w_wdata_g;
            s_wstrb  = w_wstrb_g;
            s_wlast  = m_wlast[r_gidx];
            s_wvalid = m_wvalid[r_gidx];
            m_wready = r_grant & {N{s_wready}};
         end
         ST_RESP: begin
            m_bvalid = r_grant & {N{s_bvalid}};
            s_bready = m_bready[r_gidx];
         end
         default: ;
      endcase
   end

   assign grant = r_grant;
   assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: master drivers push expected AW/W items and serve order,
// a negedge monitor pops them as the shared port handshakes; scenario tasks add timing checks.
module tb_axi_write_arbiter;

   localparam int NM  = 2;
   localparam int TMO = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [32*NM-1:0]   m_awaddr;
   logic [8*NM-1:0]    m_awlen;
   logic [3*NM-1:0]    m_awsize;
   logic [NM-1:0]      m_awvalid;
   logic [NM-1:0]      m_awready;
   logic [32*NM-1:0]   m_wdata;
   logic [4*NM-1:0]    m_wstrb;
   logic [NM-1:0]      m_wlast;
   logic [NM-1:0]      m_wvalid;
   logic [NM-1:0]      m_wready;
   logic [NM-1:0]      m_bvalid;
   logic [NM-1:0]      m_bready;
   logic [31:0]        s_awaddr;
   logic [7:0]         s_awlen;
   logic [2:0]         s_awsize;
   logic               s_awvalid;
   logic               s_awready;
   logic [31:0]        s_wdata;
   logic [3:0]         s_wstrb;
   logic               s_wlast;
   logic               s_wvalid;
   logic               s_wready;
   logic               s_bvalid;
   logic               s_bready;
   logic [NM-1:0]      grant;
   logic               busy;

   axi_write_arbiter #(.NUM_MASTERS(NM)) dut (
      .clk(clk), .rst(rst),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant(grant), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } aw_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_t;

   aw_t exp_aw[NM][$];
   w_t  exp_w[NM][$];
   int  exp_order[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int cur_m  = 0;

   int stall_at  = 0;
   int stall_len = 0;
   int b_delay   = 2;

   function automatic logic [31:0] beat_data(input int m, input logic [31:0] addr, input int b);
      return addr ^ (32'(b) * 32'h0101_0101) ^ (32'(m) << 28);
   endfunction

   function automatic logic [3:0] beat_strb(input int m, input int b);
      return 4'(b + m + 1);
   endfunction

   // Slave model: always accepts AW, optionally stalls W, answers B after b_delay cycles.
   initial begin
      int  bcnt;
      int  w_beats;
      int  stall_left;
      logic rst_s, w_hs, wl_hs, b_hs;
      s_awready  = 1'b1;
      s_wready   = 1'b1;
      s_bvalid   = 1'b0;
      bcnt       = 0;
      w_beats    = 0;
      stall_left = 0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         w_hs  = s_wvalid && s_wready;
         wl_hs = w_hs && s_wlast;
         b_hs  = s_bvalid && s_bready;
         @(posedge clk);
         #1;
         if (rst_s) begin
            s_bvalid   = 1'b0;
            s_wready   = 1'b1;
            bcnt       = 0;
            w_beats    = 0;
            stall_left = 0;
         end else begin
            if (w_hs) begin
               w_beats++;
               if (stall_at != 0 && w_beats == stall_at) stall_left = stall_len;
            end else if (stall_left > 0) begin
               stall_left--;
            end
            s_wready = (stall_left == 0);
            if (wl_hs) begin
               w_beats = 0;
               bcnt    = b_delay;
            end
            if (bcnt > 0) begin
               bcnt--;
               if (bcnt == 0) s_bvalid = 1'b1;
            end
            if (b_hs) s_bvalid = 1'b0;
         end
      end
   end

   // Scoreboard monitor on the shared port.
   initial begin
      logic [NM-1:0] mon_oh;
      aw_t           mon_aw;
      w_t            mon_w;
      forever begin
         @(negedge clk);
         if (!rst && s_awvalid && s_awready) begin
            n_cmp++;
            if (exp_order.size() == 0) begin
               n_fail++;
               $display("FAIL aw_unexpected: got AW addr %h, required no AW", s_awaddr);
            end else begin
               cur_m  = exp_order.pop_front();
               mon_oh = '0;
               mon_oh[cur_m] = 1'b1;
               $display("aw  master=%0d addr=%h len=%0d size=%0d", cur_m, s_awaddr, s_awlen, s_awsize);
               n_cmp++;
               if (grant !== mon_oh) begin
                  n_fail++;
                  $display("FAIL aw_grant: got %b, required %b", grant, mon_oh);
               end
               n_cmp++;
               if (exp_aw[cur_m].size() == 0) begin
                  n_fail++;
                  $display("FAIL aw_fields: got AW addr %h, required none queued for master %0d", s_awaddr, cur_m);
               end else begin
                  mon_aw = exp_aw[cur_m].pop_front();
                  if ({s_awaddr, s_awlen, s_awsize} !== mon_aw) begin
                     n_fail++;
                     $display("FAIL aw_fields: got %h/%0d/%0d, required %h/%0d/%0d",
                              s_awaddr, s_awlen, s_awsize, mon_aw.addr, mon_aw.len, mon_aw.size);
                  end
               end
            end
         end
         if (!rst && s_wvalid && s_wready) begin
            mon_oh = '0;
            mon_oh[cur_m] = 1'b1;
            n_cmp++;
            if (exp_w[cur_m].size() == 0) begin
               n_fail++;
               $display("FAIL w_beat: got data %h, required no beat for master %0d", s_wdata, cur_m);
            end else begin
               mon_w = exp_w[cur_m].pop_front();
               if ({s_wdata, s_wstrb, s_wlast} !== mon_w) begin
                  n_fail++;
                  $display("FAIL w_beat: got %h/%h/%b, required %h/%h/%b",
                           s_wdata, s_wstrb, s_wlast, mon_w.data, mon_w.strb, mon_w.last);
               end
            end
            n_cmp++;
            if (m_wready !== mon_oh) begin
               n_fail++;
               $display("FAIL w_ready_route: got %b, required %b", m_wready, mon_oh);
            end
         end
         if (!rst && s_bvalid && s_bready) begin
            mon_oh = '0;
            mon_oh[cur_m] = 1'b1;
            $display("b   master=%0d", cur_m);
            n_cmp++;
            if (m_bvalid !== mon_oh) begin
               n_fail++;
               $display("FAIL b_route: got m_bvalid %b, required %b", m_bvalid, mon_oh);
            end
         end
      end
   end

   task automatic master_write(input int m, input logic [31:0] addr, input logic [7:0] len);
      int t;
      m_awaddr[m*32 +: 32] = addr;
      m_awlen[m*8 +: 8]    = len;
      m_awsize[m*3 +: 3]   = 3'd2;
      m_awvalid[m]         = 1'b1;
      exp_aw[m].push_back(aw_t'({addr, len, 3'd2}));
      for (t = 0; t < TMO; t++) begin
         @(negedge clk);
         if (m_awready[m]) break;
      end
      n_cmp++;
      if (t == TMO) begin
         n_fail++;
         $display("FAIL aw_timeout: master %0d awready low, required high within %0d cycles", m, TMO);
      end
      @(posedge clk);
      #1;
      m_awvalid[m]         = 1'b0;
      m_awaddr[m*32 +: 32] = '0;
      m_awlen[m*8 +: 8]    = '0;
      m_awsize[m*3 +: 3]   = '0;
      for (int b = 0; b <= int'(len); b++) begin
         m_wdata[m*32 +: 32] = beat_data(m, addr, b);
         m_wstrb[m*4 +: 4]   = beat_strb(m, b);
         m_wlast[m]          = (b == int'(len));
         m_wvalid[m]         = 1'b1;
         exp_w[m].push_back(w_t'({beat_data(m, addr, b), beat_strb(m, b), (b == int'(len))}));
         for (t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (m_wready[m]) break;
         end
         n_cmp++;
         if (t == TMO) begin
            n_fail++;
            $display("FAIL w_timeout: master %0d beat %0d wready low, required high within %0d cycles", m, b, TMO);
         end
         @(posedge clk);
         #1;
      end
      m_wvalid[m]         = 1'b0;
      m_wlast[m]          = 1'b0;
      m_wdata[m*32 +: 32] = '0;
      m_wstrb[m*4 +: 4]   = '0;
      m_bready[m]         = 1'b1;
      for (t = 0; t < TMO; t++) begin
         @(negedge clk);
         if (m_bvalid[m]) break;
      end
      n_cmp++;
      if (t == TMO) begin
         n_fail++;
         $display("FAIL b_timeout: master %0d bvalid low, required high within %0d cycles", m, TMO);
      end
      @(posedge clk);
      #1;
      m_bready[m] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (grant !== '0) begin
         n_fail++;
         $display("FAIL reset_grant: got %b, required %b", grant, {NM{1'b0}});
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      n_cmp++;
      if ({s_awvalid, s_wvalid, s_bready} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_s_valids: got %b, required 000", {s_awvalid, s_wvalid, s_bready});
      end
      n_cmp++;
      if ({m_awready, m_wready, m_bvalid} !== '0) begin
         n_fail++;
         $display("FAIL reset_m_handshake: got %b, required all zero", {m_awready, m_wready, m_bvalid});
      end
      n_cmp++;
      if ({s_awaddr, s_wdata} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_s_data: got %h/%h, required 0/0", s_awaddr, s_wdata);
      end
   endtask

   task automatic test_round_robin();
      @(posedge clk);
      #1;
      exp_order.push_back(0);
      exp_order.push_back(1);
      exp_order.push_back(0);
      fork
         begin
            master_write(0, 32'h0000_A000, 8'd1);
            master_write(0, 32'h0000_A100, 8'd0);
         end
         master_write(1, 32'h0000_B000, 8'd2);
      join
      exp_order.push_back(1);
      exp_order.push_back(0);
      fork
         master_write(0, 32'h0000_A200, 8'd0);
         master_write(1, 32'h0000_B100, 8'd1);
         begin
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if (grant !== 2'b10) begin
               n_fail++;
               $display("FAIL rr_alternate: got grant %b, required 10", grant);
            end
         end
      join
   endtask

   task automatic test_single();
      @(posedge clk);
      #1;
      exp_order.push_back(0);
      fork
         master_write(0, 32'h0000_1000, 8'd3);
         begin
            @(negedge clk);
            n_cmp++;
            if ({s_awvalid, busy} !== 2'b00) begin
               n_fail++;
               $display("FAIL single_arb_cycle: got awvalid/busy %b, required 00", {s_awvalid, busy});
            end
            @(negedge clk);
            n_cmp++;
            if (s_awaddr !== 32'h0000_1000 || s_awvalid !== 1'b1) begin
               n_fail++;
               $display("FAIL single_aw_latency: got addr %h valid %b, required 00001000 1", s_awaddr, s_awvalid);
            end
            n_cmp++;
            if ({grant, busy} !== 3'b011) begin
               n_fail++;
               $display("FAIL single_grant: got grant/busy %b, required 011", {grant, busy});
            end
         end
      join
      @(negedge clk);
      n_cmp++;
      if ({grant, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL single_release: got grant/busy %b, required 000", {grant, busy});
      end
   endtask

   task automatic test_pending();
      @(posedge clk);
      #1;
      exp_order.push_back(0);
      exp_order.push_back(1);
      fork
         master_write(0, 32'h0000_2000, 8'd3);
         begin
            repeat (3) @(posedge clk);
            #1;
            master_write(1, 32'h0000_2800, 8'd1);
         end
         begin
            int t;
            for (t = 0; t < TMO; t++) begin
               @(negedge clk);
               n_cmp++;
               if (m_awready[1] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL pend_awready1: got %b, required 0 before master 0 B", m_awready[1]);
               end
               if (m_bvalid[0] && m_bready[0]) break;
            end
            n_cmp++;
            if (t == TMO) begin
               n_fail++;
               $display("FAIL pend_b0_timeout: master 0 B absent, required within %0d cycles", TMO);
            end
            @(negedge clk);
            n_cmp++;
            if (grant !== 2'b00) begin
               n_fail++;
               $display("FAIL pend_idle_gap: got grant %b, required 00", grant);
            end
            @(negedge clk);
            n_cmp++;
            if (grant !== 2'b10) begin
               n_fail++;
               $display("FAIL pend_grant1: got grant %b, required 10", grant);
            end
         end
      join
   endtask

   task automatic test_stall();
      @(posedge clk);
      #1;
      stall_at  = 2;
      stall_len = 3;
      exp_order.push_back(0);
      fork
         master_write(0, 32'h0000_5000, 8'd3);
         begin
            int t;
            for (t = 0; t < TMO; t++) begin
               @(negedge clk);
               if (s_wvalid && !s_wready) break;
            end
            n_cmp++;
            if (t == TMO) begin
               n_fail++;
               $display("FAIL stall_absent: no stalled beat seen, required within %0d cycles", TMO);
            end
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               n_cmp++;
               if (s_wdata !== beat_data(0, 32'h0000_5000, 2) || s_wvalid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL stall_hold: cycle %0d got %h valid %b, required %h 1",
                           i, s_wdata, s_wvalid, beat_data(0, 32'h0000_5000, 2));
               end
               n_cmp++;
               if (m_wready !== 2'b00) begin
                  n_fail++;
                  $display("FAIL stall_wready: cycle %0d got %b, required 00", i, m_wready);
               end
            end
         end
      join
      stall_at = 0;
   endtask

   task automatic test_reset_mid();
      int t;
      @(posedge clk);
      #1;
      exp_order.push_back(0);
      m_awaddr[31:0] = 32'h0000_3000;
      m_awlen[7:0]   = 8'd7;
      m_awsize[2:0]  = 3'd2;
      m_awvalid[0]   = 1'b1;
      exp_aw[0].push_back(aw_t'({32'h0000_3000, 8'd7, 3'd2}));
      for (t = 0; t < TMO; t++) begin
         @(negedge clk);
         if (m_awready[0]) break;
      end
      n_cmp++;
      if (t == TMO) begin
         n_fail++;
         $display("FAIL rmid_aw_timeout: awready low, required high within %0d cycles", TMO);
      end
      @(posedge clk);
      #1;
      m_awvalid[0]   = 1'b0;
      m_awaddr[31:0] = '0;
      m_awlen[7:0]   = '0;
      m_awsize[2:0]  = '0;
      m_wdata[31:0]  = beat_data(0, 32'h0000_3000, 0);
      m_wstrb[3:0]   = beat_strb(0, 0);
      m_wlast[0]     = 1'b0;
      m_wvalid[0]    = 1'b1;
      m_bready[0]    = 1'b1;
      exp_w[0].push_back(w_t'({beat_data(0, 32'h0000_3000, 0), beat_strb(0, 0), 1'b0}));
      @(posedge clk);
      #1;
      m_wdata[31:0] = beat_data(0, 32'h0000_3000, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({grant, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL rmid_state: got grant/busy %b, required 000", {grant, busy});
      end
      n_cmp++;
      if ({s_awvalid, s_wvalid, s_bready} !== 3'b000) begin
         n_fail++;
         $display("FAIL rmid_s_valids: got %b, required 000", {s_awvalid, s_wvalid, s_bready});
      end
      m_wvalid[0]   = 1'b0;
      m_wdata[31:0] = '0;
      m_wstrb[3:0]  = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (m_bvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_no_b: got m_bvalid %b, required 00", m_bvalid);
         end
      end
      m_bready[0] = 1'b0;
      @(posedge clk);
      #1;
      exp_order.push_back(1);
      master_write(1, 32'h0000_4000, 8'd1);
   endtask

   initial begin
      int leftover;
      rst       = 1'b1;
      m_awaddr  = '0;
      m_awlen   = '0;
      m_awsize  = '0;
      m_awvalid = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_pending();
      test_stall();
      test_reset_mid();
      repeat (3) @(posedge clk);
      leftover = exp_order.size();
      for (int m = 0; m < NM; m++) leftover += exp_aw[m].size() + exp_w[m].size();
      n_cmp++;
      if (leftover != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d unmatched items, required 0", leftover);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

endmodule
